// File: rtl/axi_lite_bram_slave_pkg.sv
// rtl/axi_lite_bram_slave_pkg.sv - shared types for the AXI-Lite pixel BRAM responder (VGA_BRAM_RD_PIPE_EN adds ST_RD_PIPE)
package axi_lite_bram_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_EXEC,
        ST_WR_RESP,
        ST_RD_ISSUE,
        ST_RD_WAIT,
`ifdef VGA_BRAM_RD_PIPE_EN
        ST_RD_PIPE,
`endif
        ST_RD_RESP
    } state_t;

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_t;

endpackage

// File: rtl/axi_lite_bram_slave_if.sv
// rtl/axi_lite_bram_slave_if.sv - AXI4-Lite bus bundle between interconnect and pixel BRAM responder
interface axi_lite_bram_slave_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_wr_capture.sv
// rtl/axi_lite_wr_capture.sv - independent AW/W holding registers with full flags
module axi_lite_wr_capture #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic                    clear,
    output logic [ADDR_WIDTH-1:0]   awaddr_q,
    output logic [DATA_WIDTH-1:0]   wdata_q,
    output logic [DATA_WIDTH/8-1:0] wstrb_q,
    output logic                    aw_full,
    output logic                    w_full
);
    assign awready = !aw_full;
    assign wready  = !w_full;

    // Address holding register: fills on handshake, emptied by the executing write
    always_ff @(posedge clk) begin
        if (reset) begin
            aw_full  <= 1'b0;
            awaddr_q <= '0;
        end else if (clear) begin
            aw_full <= 1'b0;
        end else if (awvalid && awready) begin
            aw_full  <= 1'b1;
            awaddr_q <= awaddr;
        end
    end

    // Data/strobe holding register, independent of the address side
    always_ff @(posedge clk) begin
        if (reset) begin
            w_full  <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (clear) begin
            w_full <= 1'b0;
        end else if (wvalid && wready) begin
            w_full  <= 1'b1;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
        end
    end
endmodule

// File: rtl/axi_lite_bram_slave.sv
// rtl/axi_lite_bram_slave.sv - AXI4-Lite word access to VGA pixel BRAM port A (VGA_BRAM_RD_PIPE_EN: 2-cycle BRAM read)
module axi_lite_bram_slave
    import axi_lite_bram_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 17,
    parameter int BRAM_DEPTH         = 19200,
    parameter int BRAM_ADDR_WIDTH    = 15
) (
    input  logic                          s00_axi_aclk,
    input  logic                          s00_axi_reset,
    axi_lite_bram_slave_if.slave          s00_axi,
    output logic                          bram_en,
    output logic [3:0]                    bram_we,
    output logic [BRAM_ADDR_WIDTH-1:0]    bram_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0] bram_wdata,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] bram_rdata
);
    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

    state_t                          state;
    grant_t                          last_grant;
    resp_t                           bresp_q;
    resp_t                           rresp_q;
    logic                            bvalid_q;
    logic                            rvalid_q;
    logic                            rd_in_range_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q;

    logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [3:0]                      wstrb_q;
    logic                            aw_full;
    logic                            w_full;
    logic                            wr_clear;

    logic [IDX_W-1:0]                aw_idx;
    logic [IDX_W-1:0]                ar_idx;
    logic                            aw_ok;
    logic                            ar_ok;
    logic                            grant_write;
    logic                            grant_read;
    logic                            unused_bits;

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return 32'(idx) < 32'(BRAM_DEPTH);
    endfunction

    axi_lite_wr_capture #(
        .ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
        .DATA_WIDTH (C_S_AXI_DATA_WIDTH)
    ) u_wr_capture (
        .clk      (s00_axi_aclk),
        .reset    (s00_axi_reset),
        .awaddr   (s00_axi.awaddr),
        .awvalid  (s00_axi.awvalid),
        .awready  (s00_axi.awready),
        .wdata    (s00_axi.wdata),
        .wstrb    (s00_axi.wstrb),
        .wvalid   (s00_axi.wvalid),
        .wready   (s00_axi.wready),
        .clear    (wr_clear),
        .awaddr_q (awaddr_q),
        .wdata_q  (wdata_q),
        .wstrb_q  (wstrb_q),
        .aw_full  (aw_full),
        .w_full   (w_full)
    );

    assign aw_idx = awaddr_q[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_idx = s00_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign aw_ok  = in_range(aw_idx);
    assign ar_ok  = in_range(ar_idx);

    // Round-robin only matters when both sides are ready; otherwise the ready side wins
    assign grant_write = (state == ST_IDLE) && aw_full && w_full &&
                         (!s00_axi.arvalid || last_grant == GRANT_READ);
    assign grant_read  = (state == ST_IDLE) && s00_axi.arvalid && !grant_write;
    assign wr_clear    = (state == ST_WR_EXEC);

    // arready stays high in IDLE so the read side is never blocked unless a write wins
    assign s00_axi.arready = (state == ST_IDLE) && !grant_write;
    assign s00_axi.bvalid  = bvalid_q;
    assign s00_axi.bresp   = bresp_q;
    assign s00_axi.rvalid  = rvalid_q;
    assign s00_axi.rresp   = rresp_q;
    assign s00_axi.rdata   = rdata_q;

    assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.araddr[1:0], awaddr_q[1:0]};

    // Transaction FSM with registered BRAM drive and response outputs
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_reset) begin
            state         <= ST_IDLE;
            last_grant    <= GRANT_READ;
            bram_en       <= 1'b0;
            bram_we       <= 4'b0;
            bram_addr     <= '0;
            bram_wdata    <= '0;
            bvalid_q      <= 1'b0;
            bresp_q       <= RESP_OKAY;
            rvalid_q      <= 1'b0;
            rresp_q       <= RESP_OKAY;
            rdata_q       <= '0;
            rd_in_range_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_write) begin
                        last_grant <= GRANT_WRITE;
                        bram_en    <= aw_ok;
                        bram_we    <= wstrb_q & {4{aw_ok}};
                        bram_addr  <= aw_idx[BRAM_ADDR_WIDTH-1:0];
                        bram_wdata <= wdata_q;
                        state      <= ST_WR_EXEC;
                    end else if (grant_read) begin
                        last_grant    <= GRANT_READ;
                        bram_en       <= ar_ok;
                        bram_we       <= 4'b0;
                        bram_addr     <= ar_idx[BRAM_ADDR_WIDTH-1:0];
                        rd_in_range_q <= ar_ok;
                        state         <= ST_RD_ISSUE;
                    end
                end
                ST_WR_EXEC: begin
                    bram_en  <= 1'b0;
                    bram_we  <= 4'b0;
                    bvalid_q <= 1'b1;
                    bresp_q  <= aw_ok ? RESP_OKAY : RESP_SLVERR;
                    state    <= ST_WR_RESP;
                end
                ST_WR_RESP: begin
                    if (s00_axi.bready) begin
                        bvalid_q <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                ST_RD_ISSUE: begin
                    bram_en <= 1'b0;
                    state   <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    rdata_q <= rd_in_range_q ? bram_rdata : '0;
`ifdef VGA_BRAM_RD_PIPE_EN
                    state   <= ST_RD_PIPE;
                end
                ST_RD_PIPE: begin
                    // Output-registered BRAM presents its data one cycle later
                    rdata_q  <= rd_in_range_q ? bram_rdata : '0;
`endif
                    rvalid_q <= 1'b1;
                    rresp_q  <= rd_in_range_q ? RESP_OKAY : RESP_SLVERR;
                    state    <= ST_RD_RESP;
                end
                ST_RD_RESP: begin
                    if (s00_axi.rready) begin
                        rvalid_q <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_bram_slave.sv
// tb/tb_axi_lite_bram_slave.sv - randomized self-checking bench for axi_lite_bram_slave
module tb_axi_lite_bram_slave;
    localparam int DEPTH = 19200;
`ifdef VGA_BRAM_RD_PIPE_EN
    localparam int RD_LAT = 4;
`else
    localparam int RD_LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [14:0] bram_addr;
    logic [31:0] bram_wdata;
    logic [31:0] bram_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int we_count = 0;
    int en_count = 0;
    logic [3:0]  last_we;
    logic [14:0] last_we_addr;

    logic [31:0] bram_mem [0:DEPTH-1];
    logic [31:0] ref_mem  [0:DEPTH-1];
    logic [31:0] bram_q, bram_q2;

    axi_lite_bram_slave_if #(.ADDR_WIDTH(17), .DATA_WIDTH(32)) s00_axi ();

    axi_lite_bram_slave dut (
        .s00_axi_aclk  (clk),
        .s00_axi_reset (rst),
        .s00_axi       (s00_axi),
        .bram_en       (bram_en),
        .bram_we       (bram_we),
        .bram_addr     (bram_addr),
        .bram_wdata    (bram_wdata),
        .bram_rdata    (bram_rdata)
    );

    always #5 clk = ~clk;

    // Port-A BRAM model: read-first, optional output register
    always @(posedge clk) begin
        if (bram_en && 32'(bram_addr) < DEPTH) begin
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) bram_mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
            bram_q <= bram_mem[bram_addr];
        end
        bram_q2 <= bram_q;
    end
`ifdef VGA_BRAM_RD_PIPE_EN
    assign bram_rdata = bram_q2;
`else
    assign bram_rdata = bram_q;
`endif

    always @(posedge clk) begin
        if (bram_en) en_count++;
        if (|bram_we) begin
            we_count++;
            last_we      = bram_we;
            last_we_addr = bram_addr;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: word-addressed memory with byte strobes, out-of-range is SLVERR
    function automatic logic [1:0] ref_write(input logic [16:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx = int'(a) / 4;
        if (idx >= DEPTH) return 2'b10;
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
        return 2'b00;
    endfunction

    function automatic logic [33:0] ref_read(input logic [16:0] a);
        int idx = int'(a) / 4;
        if (idx >= DEPTH) return {2'b10, 32'h0};
        return {2'b00, ref_mem[idx]};
    endfunction

    task automatic aw_send(input logic [16:0] a);
        int n = 0;
        s00_axi.awaddr = a; s00_axi.awvalid = 1'b1;
        @(negedge clk);
        while (!s00_axi.awready && n < 100) begin @(negedge clk); n++; end
        check_eq("aw_handshake", 32'(n < 100), 32'd1);
        @(posedge clk); #1;
        s00_axi.awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        s00_axi.wdata = d; s00_axi.wstrb = s; s00_axi.wvalid = 1'b1;
        @(negedge clk);
        while (!s00_axi.wready && n < 100) begin @(negedge clk); n++; end
        check_eq("w_handshake", 32'(n < 100), 32'd1);
        @(posedge clk); #1;
        s00_axi.wvalid = 1'b0;
    endtask

    task automatic axi_write(input logic [16:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] r);
        int n = 0;
        fork
            begin
                if (aw_dly > 0) begin repeat (aw_dly) @(posedge clk); #1; end
                aw_send(a);
            end
            begin
                if (w_dly > 0) begin repeat (w_dly) @(posedge clk); #1; end
                w_send(d, s);
            end
        join
        @(negedge clk);
        while (!s00_axi.bvalid && n < 100) begin @(negedge clk); n++; end
        check_eq("bvalid_timeout", 32'(n < 100), 32'd1);
        r = s00_axi.bresp;
        for (int k = 0; k < b_dly; k++) begin
            @(negedge clk);
            check_eq("bvalid_hold", 32'(s00_axi.bvalid), 32'd1);
            check_eq("bresp_hold", 32'(s00_axi.bresp), 32'(r));
        end
        s00_axi.bready = 1'b1;
        @(posedge clk); #1;
        s00_axi.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [16:0] a, input int r_dly,
                            output logic [31:0] d, output logic [1:0] r, output int lat);
        int n = 0;
        s00_axi.araddr = a; s00_axi.arvalid = 1'b1;
        @(negedge clk);
        while (!s00_axi.arready && n < 100) begin @(negedge clk); n++; end
        check_eq("ar_handshake", 32'(n < 100), 32'd1);
        @(posedge clk); #1;
        s00_axi.arvalid = 1'b0;
        @(negedge clk);
        lat = 1;
        while (!s00_axi.rvalid && lat < 100) begin @(negedge clk); lat++; end
        repeat (r_dly) @(negedge clk);
        d = s00_axi.rdata; r = s00_axi.rresp;
        s00_axi.rready = 1'b1;
        @(posedge clk); #1;
        s00_axi.rready = 1'b0;
    endtask

    initial begin
        logic [1:0]  r, er;
        logic [31:0] d;
        logic [33:0] ex;
        logic [16:0] a;
        int lat, wc, ec, n;

        for (int i = 0; i < DEPTH; i++) begin bram_mem[i] = '0; ref_mem[i] = '0; end
        bram_q = '0; bram_q2 = '0;
        s00_axi.awaddr = '0; s00_axi.awprot = '0; s00_axi.awvalid = 1'b0;
        s00_axi.wdata = '0; s00_axi.wstrb = '0; s00_axi.wvalid = 1'b0; s00_axi.bready = 1'b0;
        s00_axi.araddr = '0; s00_axi.arprot = '0; s00_axi.arvalid = 1'b0; s00_axi.rready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_awready", 32'(s00_axi.awready), 32'd1);
        check_eq("rst_wready", 32'(s00_axi.wready), 32'd1);
        check_eq("rst_arready", 32'(s00_axi.arready), 32'd1);
        check_eq("rst_bvalid", 32'(s00_axi.bvalid), 32'd0);
        check_eq("rst_rvalid", 32'(s00_axi.rvalid), 32'd0);
        check_eq("rst_rdata", s00_axi.rdata, 32'd0);
        check_eq("rst_bram_en", 32'(bram_en), 32'd0);
        check_eq("rst_bram_we", 32'(bram_we), 32'd0);
        @(posedge clk); #1;

        // Sequential words then readback
        for (int i = 0; i < 4; i++) begin
            er = ref_write(17'(i * 4), 32'(i + 1), 4'hF);
            axi_write(17'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0, r);
            check_eq("seq_bresp", 32'(r), 32'(er));
        end
        for (int i = 0; i < 4; i++) begin
            ex = ref_read(17'(i * 4));
            axi_read(17'(i * 4), 0, d, r, lat);
            check_eq("seq_rdata", d, ex[31:0]);
            check_eq("seq_rresp", 32'(r), 32'(ex[33:32]));
            check_eq("seq_rd_latency", 32'(lat), 32'(RD_LAT));
            check_eq("seq_bram_word", bram_mem[i], 32'(i + 1));
        end

        // W leads AW by three cycles, response held off for five
        wc = we_count;
        er = ref_write(17'h10, 32'hDEADBEEF, 4'hF);
        axi_write(17'h10, 32'hDEADBEEF, 4'hF, 3, 0, 5, r);
        check_eq("wlead_bresp", 32'(r), 32'(er));
        check_eq("wlead_we_pulses", 32'(we_count - wc), 32'd1);
        check_eq("wlead_we_value", 32'(last_we), 32'hF);
        check_eq("wlead_we_addr", 32'(last_we_addr), 32'd4);

        // Partial strobes merge into existing word
        er = ref_write(17'h14, 32'h11223344, 4'hF);
        axi_write(17'h14, 32'h11223344, 4'hF, 0, 0, 0, r);
        er = ref_write(17'h14, 32'hAABBCCDD, 4'b0101);
        axi_write(17'h14, 32'hAABBCCDD, 4'b0101, 0, 1, 0, r);
        ex = ref_read(17'h14);
        axi_read(17'h14, 2, d, r, lat);
        check_eq("strb_rdata", d, ex[31:0]);
        check_eq("strb_rdata_const", d, 32'h11BB33DD);

        // First out-of-range word
        wc = we_count; ec = en_count;
        er = ref_write(17'h12C00, 32'h55AA55AA, 4'hF);
        axi_write(17'h12C00, 32'h55AA55AA, 4'hF, 0, 0, 0, r);
        check_eq("oor_bresp", 32'(r), 32'(er));
        check_eq("oor_bresp_const", 32'(r), 32'h2);
        check_eq("oor_no_we", 32'(we_count - wc), 32'd0);
        ex = ref_read(17'h12C00);
        axi_read(17'h12C00, 0, d, r, lat);
        check_eq("oor_rresp", 32'(r), 32'(ex[33:32]));
        check_eq("oor_rdata", d, ex[31:0]);
        check_eq("oor_no_en", 32'(en_count - ec), 32'd0);

        // Back-to-back arbitration conflicts: W1 wins, then R wins over W2
        s00_axi.awaddr = 17'h20; s00_axi.wdata = 32'hC0FFEE01; s00_axi.wstrb = 4'hF;
        s00_axi.awvalid = 1'b1; s00_axi.wvalid = 1'b1;
        @(negedge clk);
        check_eq("cf_capture_ready", 32'(s00_axi.awready & s00_axi.wready), 32'd1);
        @(posedge clk); #1;
        s00_axi.awvalid = 1'b0; s00_axi.wvalid = 1'b0;
        s00_axi.araddr = 17'h20; s00_axi.arvalid = 1'b1;
        er = ref_write(17'h20, 32'hC0FFEE01, 4'hF);
        ex = ref_read(17'h20);
        @(negedge clk);
        check_eq("cf1_write_first", 32'(s00_axi.arready), 32'd0);
        @(posedge clk); #1;
        s00_axi.awaddr = 17'h20; s00_axi.wdata = 32'hC0FFEE02;
        s00_axi.awvalid = 1'b1; s00_axi.wvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(s00_axi.awready && s00_axi.wready) && n < 50) begin @(negedge clk); n++; end
        check_eq("cf_refill", 32'(n < 50), 32'd1);
        @(posedge clk); #1;
        s00_axi.awvalid = 1'b0; s00_axi.wvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!s00_axi.bvalid && n < 50) begin @(negedge clk); n++; end
        check_eq("cf1_bresp", 32'(s00_axi.bresp), 32'(er));
        s00_axi.bready = 1'b1;
        @(posedge clk); #1;
        s00_axi.bready = 1'b0;
        @(negedge clk);
        check_eq("cf2_read_first", 32'(s00_axi.arready), 32'd1);
        @(posedge clk); #1;
        s00_axi.arvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!s00_axi.rvalid && n < 50) begin @(negedge clk); n++; end
        check_eq("cf_rdata_order", s00_axi.rdata, ex[31:0]);
        s00_axi.rready = 1'b1;
        @(posedge clk); #1;
        s00_axi.rready = 1'b0;
        er = ref_write(17'h20, 32'hC0FFEE02, 4'hF);
        n = 0;
        @(negedge clk);
        while (!s00_axi.bvalid && n < 50) begin @(negedge clk); n++; end
        check_eq("cf2_bresp", 32'(s00_axi.bresp), 32'(er));
        s00_axi.bready = 1'b1;
        @(posedge clk); #1;
        s00_axi.bready = 1'b0;

        // Reset while the read is waiting on BRAM data
        s00_axi.araddr = 17'h0; s00_axi.arvalid = 1'b1;
        @(negedge clk);
        check_eq("rstmid_arready", 32'(s00_axi.arready), 32'd1);
        @(posedge clk); #1;
        s00_axi.arvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rstmid_rvalid", 32'(s00_axi.rvalid), 32'd0);
        check_eq("rstmid_arready_idle", 32'(s00_axi.arready), 32'd1);
        check_eq("rstmid_bram_en", 32'(bram_en), 32'd0);
        @(posedge clk); #1;
        ex = ref_read(17'h20);
        axi_read(17'h20, 0, d, r, lat);
        check_eq("rstmid_after_rdata", d, ex[31:0]);
        check_eq("rstmid_after_lat", 32'(lat), 32'(RD_LAT));

        // Randomized traffic against the reference model
        for (int it = 0; it < 40; it++) begin
            int idx;
            idx = ($urandom_range(0, 7) == 0) ? DEPTH + int'($urandom_range(0, 50)) : int'($urandom_range(0, 31));
            a = 17'(idx * 4 + int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                wc = int'($urandom_range(0, 15));
                er = ref_write(a, d, 4'(wc));
                axi_write(a, d, 4'(wc), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 2)), r);
                check_eq("rnd_bresp", 32'(r), 32'(er));
            end else begin
                ex = ref_read(a);
                axi_read(a, int'($urandom_range(0, 2)), d, r, lat);
                check_eq("rnd_rdata", d, ex[31:0]);
                check_eq("rnd_rresp", 32'(r), 32'(ex[33:32]));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
